mig_cmd_issuer: RTL and testbench
=================================

// Module: mig_cmd_issuer
// PURPOSE
//   Consumes 31-bit test descriptors from the upstream descriptor generator and
//   drives one MIG user port: command, write-data and read-data FIFOs.
//   Writes push a BL-word burst of address-derived data. Reads fetch a burst and
//   compare it against the same pattern.
//   Pulses mc_wr_rdy once per completed descriptor, which advances the generator.
// PARAMETERS
//   BL       8     words per burst (1..64); p0_cmd_bl = BL-1
//   TIMEOUT  1023  max cycles waiting for read data before flagging error
// PORTS
//   clk               in   1   single clock, all logic rising-edge
//   rst_n             in   1   asynchronous active-low reset
//   calib_done        in   1   MIG calibration complete
//   desc_data         in   31  descriptor: [30]=op (1 write, 0 read), [29:0] byte addr
//   mc_wr_rdy         out  1   1-cycle pulse: descriptor consumed, upstream may advance
//   p0_cmd_en         out  1   command push strobe
//   p0_cmd_instr      out  3   3'b000 write, 3'b001 read
//   p0_cmd_bl         out  6   burst length minus one
//   p0_cmd_byte_addr  out  30  word-aligned byte address
//   p0_cmd_full       in   1   command FIFO full
//   p0_wr_en          out  1   write-data push strobe
//   p0_wr_data        out  32  write data
//   p0_wr_mask        out  4   always 4'b0000
//   p0_wr_full        in   1   write-data FIFO full
//   p0_rd_en          out  1   read-data pop strobe
//   p0_rd_data        in   32  read data, valid when p0_rd_empty=0
//   p0_rd_empty       in   1   read-data FIFO empty
//   err               out  1   sticky: any miscompare or timeout
//   err_cnt           out  16  miscompared words + timeouts, saturating
//   done_cnt          out  16  completed descriptors, wraps
// BEHAVIOUR
//   Reset: all outputs 0, FSM=IDLE, counters 0, err=0.
//   Latched addr A = {desc_data[29:2],2'b00}. Expected/write word i = {2'b00,A}+i, i=0..BL-1.
//   FSM:
//     IDLE  : if calib_done, latch desc_data/op -> WDATA (op=1) or RCMD (op=0).
//             Holds while calib_done=0.
//     WDATA : p0_wr_en=1 with word i when !p0_wr_full; i++ on each push.
//             After word BL-1 -> WCMD. Stalls while full.
//     WCMD  : p0_cmd_en=1, instr 000, when !p0_cmd_full. One push, then -> ACK.
//     RCMD  : p0_cmd_en=1, instr 001, when !p0_cmd_full. One push, then -> RDATA.
//             Clears i and timeout counter.
//     RDATA : p0_rd_en = !p0_rd_empty. Compare p0_rd_data with word i on each pop.
//             Miscompare: err<=1, err_cnt++.
//             Timeout counter resets on each pop and increments otherwise.
//             Reaching TIMEOUT: err<=1, err_cnt++ -> ACK.
//             After word BL-1 popped -> ACK.
//     ACK   : mc_wr_rdy=1 for exactly one cycle, done_cnt++ -> IDLE.
//   Upstream updates desc_data on the edge that samples mc_wr_rdy.
//   IDLE therefore sees the next descriptor. No extra wait cycle.
//   desc_data is sampled only in IDLE. Changes elsewhere are ignored.
//   p0_cmd_en/p0_wr_en/p0_rd_en are never high while the matching full/empty is high.
//   Each strobe pushes/pops exactly one entry.
//   calib_done dropping mid-descriptor does not abort; the checked state is IDLE only.
//   err_cnt saturates at 16'hFFFF. done_cnt wraps 16'hFFFF -> 0.
//   rst_n low mid-burst: immediate return to reset values. Partial FIFO state is not cleaned up.
// TESTING
//   1. calib_done=0, desc=31'h4000_20C0 -> no strobes. Raise calib_done ->
//      8 wr_en words 0x20C0..0x20C7, cmd instr 000 addr 0x20C0 bl 7, one mc_wr_rdy.
//   2. Read desc 31'h0000_20C0, model returns 0x20C0..0x20C7 ->
//      err=0, done_cnt+1, rd_en count 8.
//   3. Read with word 3 corrupted -> err=1, err_cnt=1, still exactly 8 pops and one mc_wr_rdy.
//   4. p0_wr_full toggled every other cycle during WDATA; then p0_cmd_full held 5 cycles ->
//      no strobe while full, word order intact, cmd_en after full drops.
//   5. Read with rd_empty held high -> after TIMEOUT cycles err=1, err_cnt=1, mc_wr_rdy pulse.
//   6. Unaligned addr 0x20C3 -> cmd addr 0x20C0.
//      rst_n low during RDATA -> all outputs 0 asynchronously, FSM=IDLE.

Source files
------------

// File: rtl/mig_cmd_issuer.sv
// mig_cmd_issuer: runs write/read-compare bursts on one MIG user port, one per upstream descriptor.
module mig_cmd_issuer #(
    parameter int BL      = 8,
    parameter int TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        calib_done,
    input  logic [30:0] desc_data,
    output logic        mc_wr_rdy,
    output logic        p0_cmd_en,
    output logic [2:0]  p0_cmd_instr,
    output logic [5:0]  p0_cmd_bl,
    output logic [29:0] p0_cmd_byte_addr,
    input  logic        p0_cmd_full,
    output logic        p0_wr_en,
    output logic [31:0] p0_wr_data,
    output logic [3:0]  p0_wr_mask,
    input  logic        p0_wr_full,
    output logic        p0_rd_en,
    input  logic [31:0] p0_rd_data,
    input  logic        p0_rd_empty,
    output logic        err,
    output logic [15:0] err_cnt,
    output logic [15:0] done_cnt
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [2:0] IDLE = 3'd0, WDATA = 3'd1, WCMD = 3'd2, RCMD = 3'd3, RDATA = 3'd4, ACK = 3'd5;
    logic [2:0]    st_q, st_d;
    logic [29:0]   addr_q, addr_d;
    logic [5:0]    idx_q, idx_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          err_q, err_d;
    logic [15:0]   err_cnt_q, err_cnt_d, done_cnt_q, done_cnt_d;
    logic [31:0]   word;
    logic          last, miss, tmo_hit;
    assign word             = {2'b00, addr_q} + {26'd0, idx_q};
    assign last             = idx_q == 6'(BL - 1);
    assign p0_wr_en         = st_q == WDATA && !p0_wr_full;
    assign p0_cmd_en        = (st_q == WCMD || st_q == RCMD) && !p0_cmd_full;
    assign p0_rd_en         = st_q == RDATA && !p0_rd_empty;
    assign p0_cmd_instr     = {2'b00, p0_cmd_en && st_q == RCMD};
    assign p0_cmd_bl        = p0_cmd_en ? 6'(BL - 1) : 6'd0;
    assign p0_cmd_byte_addr = addr_q;
    assign p0_wr_data       = word;
    assign p0_wr_mask       = 4'b0000;
    assign mc_wr_rdy        = st_q == ACK;
    assign err              = err_q;
    assign err_cnt          = err_cnt_q;
    assign done_cnt         = done_cnt_q;
    assign miss             = p0_rd_en && p0_rd_data != word;
    // the wait budget expires on the TIMEOUT-th consecutive cycle without a pop
    assign tmo_hit          = st_q == RDATA && !p0_rd_en && tmo_q == TW'(TIMEOUT - 1);
    always_comb begin
        st_d       = st_q;
        addr_d     = addr_q;
        idx_d      = idx_q;
        tmo_d      = tmo_q;
        done_cnt_d = done_cnt_q;
        err_d      = err_q || miss || tmo_hit;
        err_cnt_d  = (miss || tmo_hit) && err_cnt_q != 16'hFFFF ? err_cnt_q + 16'd1 : err_cnt_q;
        case (st_q)
            IDLE: if (calib_done) begin
                addr_d = {desc_data[29:2], 2'b00};
                idx_d  = 6'd0;
                st_d   = desc_data[30] ? WDATA : RCMD;
            end
            WDATA: if (p0_wr_en) begin
                idx_d = idx_q + 6'd1;
                st_d  = last ? WCMD : WDATA;
            end
            WCMD: st_d = p0_cmd_en ? ACK : WCMD;
            RCMD: if (p0_cmd_en) begin
                idx_d = 6'd0;
                tmo_d = '0;
                st_d  = RDATA;
            end
            RDATA: if (p0_rd_en) begin
                tmo_d = '0;
                idx_d = idx_q + 6'd1;
                st_d  = last ? ACK : RDATA;
            end else begin
                tmo_d = tmo_hit ? tmo_q : tmo_q + 1'b1;
                st_d  = tmo_hit ? ACK : RDATA;
            end
            ACK: begin
                done_cnt_d = done_cnt_q + 16'd1;
                st_d       = IDLE;
            end
            default: st_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q       <= IDLE;
            addr_q     <= '0;
            idx_q      <= '0;
            tmo_q      <= '0;
            err_q      <= 1'b0;
            err_cnt_q  <= '0;
            done_cnt_q <= '0;
        end else begin
            st_q       <= st_d;
            addr_q     <= addr_d;
            idx_q      <= idx_d;
            tmo_q      <= tmo_d;
            err_q      <= err_d;
            err_cnt_q  <= err_cnt_d;
            done_cnt_q <= done_cnt_d;
        end
    end
endmodule

// File: tb/tb_mig_cmd_issuer.sv
// tb_mig_cmd_issuer: directed write/read/stall/timeout/reset vectors against a tiny MIG port model.
module tb_mig_cmd_issuer;
    logic        clk = 0, rst_n = 0, calib_done = 0;
    logic [30:0] desc_data = '0;
    logic        p0_cmd_full = 0, p0_wr_full = 0, force_empty = 0;
    logic        mc_wr_rdy, p0_cmd_en, p0_wr_en, p0_rd_en, p0_rd_empty, err;
    logic [2:0]  p0_cmd_instr;
    logic [5:0]  p0_cmd_bl;
    logic [29:0] p0_cmd_byte_addr;
    logic [31:0] p0_wr_data, p0_rd_data;
    logic [3:0]  p0_wr_mask;
    logic [15:0] err_cnt, done_cnt;
    logic [31:0] rmem [0:31];
    logic [31:0] wlog [0:63];
    int          rp = 0, rn = 0, wn = 0, cmd_n = 0, rd_n = 0, ack_n = 0, viol = 0;
    logic        pop = 0;
    logic [2:0]  c_instr = '0;
    logic [29:0] c_addr = '0;
    logic [5:0]  c_bl = '0;
    int          tests = 0, fails = 0;
    int          bw, bc, br, ba, cyc;
    always #5 clk = ~clk;
    assign p0_rd_empty = force_empty || rp == rn;
    assign p0_rd_data  = rmem[rp[4:0]];
    mig_cmd_issuer dut (
        .clk(clk), .rst_n(rst_n), .calib_done(calib_done), .desc_data(desc_data),
        .mc_wr_rdy(mc_wr_rdy), .p0_cmd_en(p0_cmd_en), .p0_cmd_instr(p0_cmd_instr),
        .p0_cmd_bl(p0_cmd_bl), .p0_cmd_byte_addr(p0_cmd_byte_addr), .p0_cmd_full(p0_cmd_full),
        .p0_wr_en(p0_wr_en), .p0_wr_data(p0_wr_data), .p0_wr_mask(p0_wr_mask),
        .p0_wr_full(p0_wr_full), .p0_rd_en(p0_rd_en), .p0_rd_data(p0_rd_data),
        .p0_rd_empty(p0_rd_empty), .err(err), .err_cnt(err_cnt), .done_cnt(done_cnt)
    );
    // strobes seen mid-cycle take effect on the following rising edge
    always @(negedge clk) begin
        if (p0_wr_en) begin
            wlog[wn[5:0]] <= p0_wr_data;
            wn <= wn + 1;
        end
        if (p0_cmd_en) begin
            cmd_n   <= cmd_n + 1;
            c_instr <= p0_cmd_instr;
            c_addr  <= p0_cmd_byte_addr;
            c_bl    <= p0_cmd_bl;
        end
        if (p0_rd_en) rd_n <= rd_n + 1;
        if (mc_wr_rdy) ack_n <= ack_n + 1;
        if ((p0_wr_en && p0_wr_full) || (p0_cmd_en && p0_cmd_full) || (p0_rd_en && p0_rd_empty)) viol <= viol + 1;
        pop <= p0_rd_en;
    end
    always @(posedge clk) begin
        #1;
        if (pop) rp <= rp + 1;
    end
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask
    task automatic snap();
        bw = wn; bc = cmd_n; br = rd_n; ba = ack_n;
    endtask
    task automatic start(input logic [30:0] d);
        snap();
        @(negedge clk);
        desc_data  = d;
        calib_done = 1;
    endtask
    task automatic wait_ack(input int max);
        cyc = 0;
        while (cyc < max) begin
            @(negedge clk);
            cyc++;
            if (mc_wr_rdy) break;
        end
        calib_done = 0;
        chk("ack_seen", {31'd0, mc_wr_rdy}, 32'd1);
        repeat (3) @(negedge clk);
        chk("ack_once", ack_n - ba, 32'd1);
    endtask
    task automatic load(input logic [31:0] base, input int bad);
        for (int i = 0; i < 8; i++) begin
            rmem[rn[4:0]] = (base + i) ^ (i == bad ? 32'h1 : 32'h0);
            rn++;
        end
    endtask
    initial begin
        #12;
        chk("rst_strobes", {mc_wr_rdy, p0_cmd_en, p0_wr_en, p0_rd_en, err}, 32'd0);
        chk("rst_cnts", {err_cnt, done_cnt}, 32'd0);
        chk("rst_data", p0_wr_data | {2'b00, p0_cmd_byte_addr}, 32'd0);
        chk("rst_state", {29'd0, dut.st_q}, 32'd0);
        @(posedge clk); #1 rst_n = 1;
        desc_data = 31'h4000_20C0;
        snap();
        repeat (6) @(negedge clk);
        chk("nocal_wr", wn - bw, 32'd0);
        chk("nocal_cmd", cmd_n - bc, 32'd0);
        start(31'h4000_20C0);
        wait_ack(100);
        chk("w_cnt", wn - bw, 32'd8);
        for (int i = 0; i < 8; i++) chk($sformatf("w_word%0d", i), wlog[bw + i], 32'h20C0 + i);
        chk("w_cmd_n", cmd_n - bc, 32'd1);
        chk("w_cmd", {c_instr, c_bl, 2'b00, c_addr}, {3'b000, 6'd7, 2'b00, 30'h20C0});
        chk("w_done", {16'd0, done_cnt}, 32'd1);
        load(32'h20C0, -1);
        start(31'h0000_20C0);
        wait_ack(100);
        chk("r_pops", rd_n - br, 32'd8);
        chk("r_cmd", {c_instr, c_bl, 2'b00, c_addr}, {3'b001, 6'd7, 2'b00, 30'h20C0});
        chk("r_err", {31'd0, err}, 32'd0);
        chk("r_done", {16'd0, done_cnt}, 32'd2);
        load(32'h20C0, 3);
        start(31'h0000_20C0);
        wait_ack(100);
        chk("bad_pops", rd_n - br, 32'd8);
        chk("bad_err", {15'd0, err, err_cnt}, {15'd0, 1'b1, 16'd1});
        chk("bad_done", {16'd0, done_cnt}, 32'd3);
        @(posedge clk); #1 p0_cmd_full = 1;
        start(31'h4000_1000);
        fork
            wait_ack(200);
            begin
                for (int i = 0; i < 20; i++) begin
                    @(posedge clk); #1 p0_wr_full = ~p0_wr_full;
                end
                p0_wr_full = 0;
                repeat (5) @(posedge clk);
                chk("stall_nocmd", cmd_n - bc, 32'd0);
                #1 p0_cmd_full = 0;
            end
        join
        chk("stall_wcnt", wn - bw, 32'd8);
        for (int i = 0; i < 8; i++) chk($sformatf("stall_word%0d", i), wlog[bw + i], 32'h1000 + i);
        chk("stall_cmd", {cmd_n - bc, 2'b00, c_addr}, {32'd1, 2'b00, 30'h1000});
        chk("no_viol", viol, 32'd0);
        @(posedge clk); #1 force_empty = 1;
        start(31'h0000_3000);
        wait_ack(1200);
        chk("tmo_cycles", cyc, 32'd1025);
        chk("tmo_err", {15'd0, err, err_cnt}, {15'd0, 1'b1, 16'd2});
        chk("tmo_pops", rd_n - br, 32'd0);
        chk("tmo_done", {16'd0, done_cnt}, 32'd5);
        start(31'h0000_20C3);
        repeat (5) @(negedge clk);
        calib_done = 0;
        chk("ua_addr", {2'b00, c_addr}, 32'h20C0);
        chk("ua_state", {29'd0, dut.st_q}, 32'd4);
        #2 rst_n = 0;
        #1;
        chk("arst_strobes", {mc_wr_rdy, p0_cmd_en, p0_wr_en, p0_rd_en, err}, 32'd0);
        chk("arst_cnts", {err_cnt, done_cnt}, 32'd0);
        chk("arst_addr", {2'b00, p0_cmd_byte_addr} | {29'd0, dut.st_q}, 32'd0);
        chk("no_viol_end", viol, 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
